trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_pkg.sv | 25 ++
 rtl/trap_sequencer.sv | 105 ++++++++++
 tb/tb_trap_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared types and defaults for the trap sequencer: FSM states, trap cause codes,
// and the boot/vector addresses.
package trap_pkg;

  typedef enum logic [1:0] {
    KERNEL = 2'd0,
    USER   = 2'd1,
    FLUSH  = 2'd2,
    VECTOR = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL_PC  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL_MEM = 2'd2;
  localparam logic [1:0] CAUSE_SYSCALL     = 2'd3;

  localparam logic [15:0] VEC_BASE_DEFAULT   = 16'h0010;
  localparam logic [15:0] USER_START_DEFAULT = 16'h0100;

  // Each cause gets a 4-byte slot above the vector base.
  function automatic logic [15:0] vector_addr(input logic [15:0] base, input logic [1:0] c);
    return base + {12'd0, c, 2'b00};
  endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Trap sequencer: takes user-mode faults and syscalls into kernel mode through a
// flush/vector sequence, and returns to user mode on rte. All outputs are registered.
//
// state  | meaning
// KERNEL | kernel mode; trap events ignored, waits for rte
// USER   | user mode; samples illegal_pc/illegal_mem/syscall
// FLUSH  | one-cycle pipeline flush after an accepted trap
// VECTOR | one-cycle redirect to the handler vector
module trap_sequencer
  import trap_pkg::*;
#(
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEFAULT,
  parameter logic [15:0] USER_START = USER_START_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        illegal_pc,
  input  logic        illegal_mem,
  input  logic        syscall,
  input  logic        rte,
  input  logic [15:0] fault_pc,
  output logic        mode,
  output logic        flush,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic [15:0] epc,
  output logic [1:0]  cause,
  output logic [7:0]  fault_count
);

  state_t      state, state_nxt;
  logic        mode_nxt, flush_nxt, redirect_nxt;
  logic [15:0] redirect_pc_nxt, epc_nxt;
  logic [1:0]  cause_nxt;
  logic [7:0]  fault_count_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= KERNEL;
      mode        <= 1'b1;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 16'h0000;
      epc         <= USER_START;
      cause       <= CAUSE_NONE;
      fault_count <= 8'h00;
    end else begin
      state       <= state_nxt;
      mode        <= mode_nxt;
      flush       <= flush_nxt;
      redirect    <= redirect_nxt;
      redirect_pc <= redirect_pc_nxt;
      epc         <= epc_nxt;
      cause       <= cause_nxt;
      fault_count <= fault_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    mode_nxt        = mode;
    flush_nxt       = 1'b0;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = redirect_pc;
    epc_nxt         = epc;
    cause_nxt       = cause;
    fault_count_nxt = fault_count;

    unique case (state)
      USER: begin
        // Faults win over a simultaneous rte; rte alone in user mode does nothing.
        if (illegal_pc || illegal_mem || syscall) begin
          if (illegal_pc)       cause_nxt = CAUSE_ILLEGAL_PC;
          else if (illegal_mem) cause_nxt = CAUSE_ILLEGAL_MEM;
          else                  cause_nxt = CAUSE_SYSCALL;
          if ((illegal_pc || illegal_mem) && fault_count != 8'hFF)
            fault_count_nxt = fault_count + 8'd1;
          epc_nxt   = fault_pc;
          mode_nxt  = 1'b1;
          flush_nxt = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        redirect_nxt    = 1'b1;
        redirect_pc_nxt = vector_addr(VEC_BASE, cause);
        state_nxt       = VECTOR;
      end
      VECTOR: begin
        state_nxt = KERNEL;
      end
      KERNEL: begin
        if (rte) begin
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = epc;
          mode_nxt        = 1'b0;
          cause_nxt       = CAUSE_NONE;
          state_nxt       = USER;
        end
      end
      default: state_nxt = KERNEL;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected redirects are queued by the stimulus
// and checked by an independent monitor; other observations are checked inline.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        illegal_pc, illegal_mem, syscall, rte;
  logic [15:0] fault_pc;
  logic        mode, flush, redirect;
  logic [15:0] redirect_pc, epc;
  logic [1:0]  cause;
  logic [7:0]  fault_count;

  typedef struct packed {
    logic [15:0] pc;
    logic        mode;
    logic [1:0]  cause;
    logic [15:0] epc;
    logic [7:0]  fc;
  } redir_t;

  redir_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     exp_fc = 0;

  trap_sequencer dut (
    .clk(clk), .rst_n(rst_n), .illegal_pc(illegal_pc), .illegal_mem(illegal_mem),
    .syscall(syscall), .rte(rte), .fault_pc(fault_pc), .mode(mode), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every redirect strobe must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (redirect === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
      end else begin
        redir_t e;
        e = exp_q.pop_front();
        check("redirect_pc", redirect_pc, e.pc);
        check("redir_mode", {15'd0, mode}, {15'd0, e.mode});
        check("redir_cause", {14'd0, cause}, {14'd0, e.cause});
        check("redir_epc", epc, e.epc);
        check("redir_fault_count", {8'd0, fault_count}, {8'd0, e.fc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rte(input logic [15:0] ret_pc);
    redir_t e;
    @(negedge clk);
    e = '{pc: ret_pc, mode: 1'b0, cause: 2'd0, epc: ret_pc, fc: exp_fc[7:0]};
    exp_q.push_back(e);
    rte = 1'b1;
    tick();
    rte = 1'b0;
    check("rte_mode", {15'd0, mode}, 16'd0);
  endtask

  // ev = {illegal_pc, illegal_mem, syscall}; also asserts rte when with_rte is set.
  task automatic do_trap(input logic [2:0] ev, input logic [15:0] pc, input logic [1:0] exp_cause,
                         input logic [15:0] vec, input logic with_rte);
    redir_t e;
    @(negedge clk);
    if (ev[2] || ev[1]) exp_fc = (exp_fc < 255) ? exp_fc + 1 : 255;
    e = '{pc: vec, mode: 1'b1, cause: exp_cause, epc: pc, fc: exp_fc[7:0]};
    exp_q.push_back(e);
    {illegal_pc, illegal_mem, syscall} = ev;
    fault_pc = pc;
    rte = with_rte;
    tick();
    {illegal_pc, illegal_mem, syscall} = 3'b000;
    rte = 1'b0;
    check("trap_flush", {15'd0, flush}, 16'd1);
    check("trap_mode", {15'd0, mode}, 16'd1);
    check("trap_cause", {14'd0, cause}, {14'd0, exp_cause});
    check("trap_epc", epc, pc);
    tick();
    check("flush_one_cycle", {15'd0, flush}, 16'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    {illegal_pc, illegal_mem, syscall, rte} = 4'b0000;
    fault_pc = 16'h0000;
    tick();
    tick();
    check("rst_mode", {15'd0, mode}, 16'd1);
    check("rst_flush", {15'd0, flush}, 16'd0);
    check("rst_redirect", {15'd0, redirect}, 16'd0);
    check("rst_redirect_pc", redirect_pc, 16'h0000);
    check("rst_epc", epc, 16'h0100);
    check("rst_cause", {14'd0, cause}, 16'd0);
    check("rst_fault_count", {8'd0, fault_count}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot: first rte goes to the user start address.
    do_rte(16'h0100);

    // rte in user mode is ignored.
    @(negedge clk);
    rte = 1'b1;
    tick();
    rte = 1'b0;
    check("user_rte_mode", {15'd0, mode}, 16'd0);

    // Priority: illegal_pc wins over illegal_mem; events masked through FLUSH/VECTOR/KERNEL.
    @(negedge clk);
    exp_fc = 1;
    exp_q.push_back('{pc: 16'h0014, mode: 1'b1, cause: 2'd1, epc: 16'h0234, fc: 8'd1});
    illegal_pc = 1'b1;
    illegal_mem = 1'b1;
    fault_pc = 16'h0234;
    tick();
    illegal_pc = 1'b0;
    fault_pc = 16'hBEEF;
    check("prio_flush", {15'd0, flush}, 16'd1);
    check("prio_cause", {14'd0, cause}, 16'd1);
    check("prio_epc", epc, 16'h0234);
    tick();
    check("prio_flush_off", {15'd0, flush}, 16'd0);
    tick();
    tick();
    tick();
    illegal_mem = 1'b0;
    check("mask_epc", epc, 16'h0234);
    check("mask_cause", {14'd0, cause}, 16'd1);
    check("mask_fault_count", {8'd0, fault_count}, 16'd1);
    check("mask_flush", {15'd0, flush}, 16'd0);
    check("mask_mode", {15'd0, mode}, 16'd1);
    do_rte(16'h0234);

    // Syscall does not count as a fault.
    do_trap(3'b001, 16'h0300, 2'd3, 16'h001C, 1'b0);
    check("syscall_fault_count", {8'd0, fault_count}, 16'd1);
    do_rte(16'h0300);

    // Fault taken over a simultaneous rte.
    do_trap(3'b010, 16'h0400, 2'd2, 16'h0018, 1'b1);
    do_rte(16'h0400);

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      do_trap(3'b010, 16'h1000 + 16'(i), 2'd2, 16'h0018, 1'b0);
      do_rte(16'h1000 + 16'(i));
    end
    check("sat_fault_count", {8'd0, fault_count}, 16'h00FF);

    // Reset while in FLUSH: no vector redirect may follow.
    @(negedge clk);
    illegal_pc = 1'b1;
    fault_pc = 16'h0500;
    tick();
    illegal_pc = 1'b0;
    check("pre_rst_flush", {15'd0, flush}, 16'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_flush", {15'd0, flush}, 16'd0);
    check("midrst_redirect", {15'd0, redirect}, 16'd0);
    check("midrst_mode", {15'd0, mode}, 16'd1);
    check("midrst_epc", epc, 16'h0100);
    check("midrst_fault_count", {8'd0, fault_count}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = 0;
    tick();
    tick();
    check("post_rst_redirect", {15'd0, redirect}, 16'd0);
    do_rte(16'h0100);

    repeat (4) tick();
    check("pending_redirects", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
